fp_alu_sequencer: RTL and testbench
===================================

Name: fp_alu_sequencer

Overview:
Issue/capture stage that sits directly upstream of the combinational floating_point_ALU and feeds it. It accepts one FP operation request at a time over a valid/ready handshake and registers the operands and opcode. It holds them stable on the ALU inputs for a per-opcode settle latency, then captures the ALU result and exception flags into an output holding register. It also accumulates sticky exception flags for software (FCSR-style).

Parameters:
LAT_ADD, 2, settle cycles for ADD/SUB (range 1..15)
LAT_MUL, 3, settle cycles for MUL (range 1..15)
LAT_DIV, 8, settle cycles for DIV (range 1..15)
LAT_MISC, 1, settle cycles for NOP/RND/CMP/INV (range 1..15)

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  sequencer can accept a request
in_op  in  3  opcode: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 RND, 6 CMP, 7 INV
in_a  in  32  operand 1, IEEE-754 single
in_b  in  32  operand 2
alu_input1  out  32  to ALU input1
alu_input2  out  32  to ALU input2
alu_operation  out  3  to ALU operation
alu_result  in  32  from ALU result
alu_flags  in  6  from ALU {division_by_zero, QNaN, SNaN, inexact, underflow, overflow}
out_valid  out  1  captured result available
out_ready  in  1  consumer accepts result
out_result  out  32  captured result
out_flags  out  6  captured flags of this operation, same bit order as alu_flags
sticky_flags  out  6  OR-accumulated flags since last clear
sticky_clear  in  1  clear sticky_flags

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. Operand, opcode and counter registers, out_result, out_flags and sticky_flags are set to 0. out_valid=0. Reset overrides everything, including an operation in progress; that operation's result is discarded with no flag update.
- in_ready = (state==IDLE), combinational from state only.
- The alu_* outputs are driven directly from the operand/opcode registers, so they are glitch-free and stable through EXEC.
- FSM states:
  - IDLE: if in_valid, latch in_a/in_b/in_op, load cnt = LAT(op)-1, go to EXEC. Otherwise stay.
  - EXEC: if cnt!=0, decrement cnt. If cnt==0, capture alu_result into out_result and alu_flags into out_flags, set out_valid=1, OR the flags into sticky_flags, go to DONE.
  - DONE: out_valid=1 and outputs are held. If out_ready, clear out_valid and go to IDLE. Otherwise stay.
- Latency: an accept at edge N gives capture at edge N+LAT(op). out_valid is high from then on. The minimum issue interval is LAT(op)+2 cycles when out_ready is held high. No overlap between requests.
- NOP: the captured flags are forced to 0 regardless of alu_flags; the result is alu_result (operand 1 passthrough).
- Sticky flags:
  - sticky_clear zeros sticky_flags at the next edge.
  - If clear and a capture occur in the same cycle, the result is sticky_flags = captured flags. The old value is cleared; the new event is not lost.
  - sticky_clear is honoured in every state.
- in_op/in_a/in_b changes while not in IDLE are ignored. in_valid while busy is not an error; the request simply waits.
- A LAT_* value of 0 is illegal; the design does not need to support it.

Test Plan:
1. Reset, then ADD in_a=0x3F800000 (1.0), in_b=0x40000000 (2.0), in_valid=1 for one cycle, out_ready=1, ALU model returns 0x40400000. Required: in_ready drops the cycle after accept; out_valid rises exactly 2 edges after accept; out_result=0x40400000, out_flags=0; in_ready returns one cycle after the out handshake.
2. DIV 1.0/0x00000000 with the ALU model asserting division_by_zero. Required: out_valid rises exactly 8 edges after accept; out_flags=6'b100000; sticky_flags=6'b100000, and it persists across a following MUL with clean flags.
3. Back-pressure: MUL completes while out_ready=0 for 5 cycles. Required: out_valid, out_result and out_flags stay stable; in_ready=0 throughout; in_a toggling has no effect; accept occurs on the first out_ready=1 cycle.
4. sticky_clear asserted in the same cycle as the capture of an op flagging overflow (6'b000001), with previous sticky 6'b100000. Required: sticky_flags=6'b000001 afterwards.
5. Assert rst mid-EXEC of DIV. Required: next edge gives state IDLE, in_ready=1, out_valid=0, and all outputs 0; sticky_flags is not updated by the aborted DIV.
6. NOP with in_a=0x7FC00000 and the ALU model driving QNaN=1. Required: after 1 cycle, out_result=0x7FC00000, out_flags=0, sticky_flags unchanged.

Source files
------------

// File: rtl/fp_alu_sequencer_if.sv
// Request, response and ALU-side signal bundle for fp_alu_sequencer.
// The sequencer takes the slave view; the environment/upstream side takes the master view.
interface fp_alu_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic [31:0] alu_input1;
  logic [31:0] alu_input2;
  logic [2:0]  alu_operation;
  logic [31:0] alu_result;
  logic [5:0]  alu_flags;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_flags;

  logic [5:0]  sticky_flags;
  logic        sticky_clear;

  modport slave (
    input  in_valid, in_op, in_a, in_b, alu_result, alu_flags, out_ready, sticky_clear,
    output in_ready, alu_input1, alu_input2, alu_operation, out_valid, out_result, out_flags,
           sticky_flags
  );

  modport master (
    output in_valid, in_op, in_a, in_b, alu_result, alu_flags, out_ready, sticky_clear,
    input  in_ready, alu_input1, alu_input2, alu_operation, out_valid, out_result, out_flags,
           sticky_flags
  );
endinterface

// File: rtl/fp_alu_sequencer.sv
// Issue/capture stage in front of a combinational FP ALU: holds operands for a per-opcode
// settle time, captures result and flags, and accumulates sticky exception flags.
module fp_alu_sequencer #(
  parameter int unsigned LAT_ADD  = 2,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_DIV  = 8,
  parameter int unsigned LAT_MISC = 1
) (
  input logic               clk,
  input logic               rst,
  fp_alu_sequencer_if.slave bus
);

  localparam logic [2:0] OpNop = 3'd0;
  localparam logic [2:0] OpAdd = 3'd1;
  localparam logic [2:0] OpSub = 3'd2;
  localparam logic [2:0] OpMul = 3'd3;
  localparam logic [2:0] OpDiv = 3'd4;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic        out_valid_q;
  logic [31:0] out_result_q;
  logic [5:0]  out_flags_q;
  logic [5:0]  sticky_q;

  logic        capture;
  logic [5:0]  cap_flags;

  function automatic logic [3:0] lat_of(input logic [2:0] op);
    unique case (op)
      OpAdd, OpSub: lat_of = 4'(LAT_ADD);
      OpMul:        lat_of = 4'(LAT_MUL);
      OpDiv:        lat_of = 4'(LAT_DIV);
      default:      lat_of = 4'(LAT_MISC);
    endcase
  endfunction

  always_comb begin
    capture   = (state_q == StExec) && (cnt_q == 4'd0);
    // NOP is a passthrough and never raises exceptions.
    cap_flags = (op_q == OpNop) ? 6'd0 : bus.alu_flags;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      op_q         <= 3'd0;
      out_valid_q  <= 1'b0;
      out_result_q <= 32'd0;
      out_flags_q  <= 6'd0;
      sticky_q     <= 6'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            op_q    <= bus.in_op;
            cnt_q   <= lat_of(bus.in_op) - 4'd1;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            out_result_q <= bus.alu_result;
            out_flags_q  <= cap_flags;
            out_valid_q  <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // A clear coinciding with a capture keeps the new event.
      if (capture) begin
        sticky_q <= (bus.sticky_clear ? 6'd0 : sticky_q) | cap_flags;
      end else if (bus.sticky_clear) begin
        sticky_q <= 6'd0;
      end
    end
  end

  assign bus.in_ready      = (state_q == StIdle);
  assign bus.alu_input1    = a_q;
  assign bus.alu_input2    = b_q;
  assign bus.alu_operation = op_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_result    = out_result_q;
  assign bus.out_flags     = out_flags_q;
  assign bus.sticky_flags  = sticky_q;

endmodule

// File: tb/tb_fp_alu_sequencer.sv
// Directed bench for fp_alu_sequencer: the stimulus thread queues expected responses and a
// monitor process checks each result handshake against the queue.
module tb_fp_alu_sequencer;

  logic clk;
  logic rst;
  fp_alu_sequencer_if bus ();

  fp_alu_sequencer #(
    .LAT_ADD (2),
    .LAT_MUL (3),
    .LAT_DIV (8),
    .LAT_MISC(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [31:0] res;
    logic [5:0]  flg;
    logic [5:0]  sticky;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a result handshake completes at the next edge whenever valid&ready at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got result %h with no expectation", bus.out_result);
        end else begin
          e = sb.pop_front();
          check("sb_result", bus.out_result, e.res);
          check("sb_flags", 32'(bus.out_flags), 32'(e.flg));
          check("sb_sticky", 32'(bus.sticky_flags), 32'(e.sticky));
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [5:0] flg, input int lat,
                        input logic [5:0] exp_flags, input logic [5:0] exp_sticky,
                        input bit clr_at_cap);
    exp_t e;
    int   guard;
    int   k;
    bus.alu_result = res;
    bus.alu_flags  = flg;
    e.res    = res;
    e.flg    = exp_flags;
    e.sticky = exp_sticky;
    sb.push_back(e);
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("accept_timeout", 32'(guard < 50), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      if (clr_at_cap && k == lat - 1) bus.sticky_clear = 1'b1;
      @(posedge clk);
      #1;
      bus.sticky_clear = 1'b0;
      k++;
    end
    check("latency", 32'(k), 32'(lat));
    check("alu_input1", bus.alu_input1, a);
    check("alu_input2", bus.alu_input2, b);
    check("alu_operation", 32'(bus.alu_operation), 32'(op));
  endtask

  initial begin
    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_op        = 3'd0;
    bus.in_a         = 32'd0;
    bus.in_b         = 32'd0;
    bus.alu_result   = 32'd0;
    bus.alu_flags    = 6'd0;
    bus.out_ready    = 1'b1;
    bus.sticky_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_sticky", 32'(bus.sticky_flags), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: ADD 1.0 + 2.0
    run_op(3'd1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 6'd0, 2, 6'd0, 6'd0, 1'b0);
    @(posedge clk);
    #1;
    check("t1_in_ready_back", 32'(bus.in_ready), 32'd1);

    // 2: DIV by zero, then a clean MUL keeps the sticky bit
    run_op(3'd4, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 6'b100000, 8, 6'b100000,
           6'b100000, 1'b0);
    @(posedge clk);
    #1;
    run_op(3'd3, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 6'd0, 3, 6'd0, 6'b100000, 1'b0);
    @(posedge clk);
    #1;
    check("t2_sticky_persist", 32'(bus.sticky_flags), 32'b100000);

    // 3: back-pressure on a MUL
    bus.out_ready = 1'b0;
    run_op(3'd3, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 6'd0, 3, 6'd0, 6'b100000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_a       = ~bus.in_a;
      bus.alu_result = 32'hDEAD_BEEF;
      bus.alu_flags  = 6'b011111;
      @(posedge clk);
      #1;
      check("t3_out_valid", 32'(bus.out_valid), 32'd1);
      check("t3_out_result", bus.out_result, 32'h4040_0000);
      check("t3_out_flags", 32'(bus.out_flags), 32'd0);
      check("t3_in_ready", 32'(bus.in_ready), 32'd0);
      check("t3_alu_input1", bus.alu_input1, 32'h3FC0_0000);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_in_ready_back", 32'(bus.in_ready), 32'd1);
    check("t3_out_valid_low", 32'(bus.out_valid), 32'd0);

    // 4: clear coincides with an overflow capture
    run_op(3'd1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 6'b000001, 2, 6'b000001,
           6'b000001, 1'b1);
    @(posedge clk);
    #1;
    check("t4_sticky", 32'(bus.sticky_flags), 32'b000001);

    // 5: reset in the middle of a DIV
    bus.alu_result = 32'h7F80_0000;
    bus.alu_flags  = 6'b100000;
    bus.in_op      = 3'd4;
    bus.in_a       = 32'h3F80_0000;
    bus.in_b       = 32'h0000_0000;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_in_ready", 32'(bus.in_ready), 32'd1);
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_out_result", bus.out_result, 32'd0);
    check("t5_out_flags", 32'(bus.out_flags), 32'd0);
    check("t5_alu_input1", bus.alu_input1, 32'd0);
    check("t5_alu_operation", 32'(bus.alu_operation), 32'd0);
    check("t5_sticky", 32'(bus.sticky_flags), 32'd0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t5_sticky_later", 32'(bus.sticky_flags), 32'd0);
    check("t5_out_valid_later", 32'(bus.out_valid), 32'd0);

    // 6: CMP sets inexact, then NOP must not add QNaN
    run_op(3'd6, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0001, 6'b000100, 1, 6'b000100,
           6'b000100, 1'b0);
    @(posedge clk);
    #1;
    run_op(3'd0, 32'h7FC0_0000, 32'h0000_0000, 32'h7FC0_0000, 6'b010000, 1, 6'd0,
           6'b000100, 1'b0);
    @(posedge clk);
    #1;
    check("t6_sticky", 32'(bus.sticky_flags), 32'b000100);

    // Clear while idle
    bus.sticky_clear = 1'b1;
    @(posedge clk);
    #1;
    bus.sticky_clear = 1'b0;
    check("idle_clear", 32'(bus.sticky_flags), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
